// File: rtl/spi_display_driver_if.sv
// Frame handshake and SPI pins of the 7-segment display driver.
interface spi_display_driver_if #(
    parameter int unsigned NUM_DIGITS = 6
);
    logic                    frame_valid;
    logic                    frame_ready;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    init_done;
    logic                    cs_n;
    logic                    sck;
    logic                    mosi;

    // Frame source / display side
    modport master (
        output frame_valid, digits, dp,
        input  frame_ready, init_done, cs_n, sck, mosi
    );

    // Driver side
    modport slave (
        input  frame_valid, digits, dp,
        output frame_ready, init_done, cs_n, sck, mosi
    );
endinterface

// File: rtl/spi_display_driver.sv
// MAX7219-style display driver: power-up register sequence, then one
// 16-bit SPI mode-0 word per digit for every accepted frame.
module spi_display_driver #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCK_HALF   = 2,
    parameter int unsigned CS_GAP     = 4,
    parameter logic [3:0]  INTENSITY  = 4'h8
) (
    input  logic                 clk,
    input  logic                 res,
    spi_display_driver_if.slave  bus
);
    localparam int unsigned DIG_W  = 4 * NUM_DIGITS;
    localparam int unsigned HALF_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int unsigned GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [2:0]        LAST_INIT   = 3'd4;
    localparam logic [2:0]        LAST_DIGIT  = 3'(NUM_DIGITS - 1);
    localparam logic [HALF_W-1:0] HALF_LAST   = HALF_W'(SCK_HALF - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(CS_GAP - 1);
    localparam logic [7:0]        DECODE_MASK = 8'((16'd1 << NUM_DIGITS) - 16'd1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_SHIFT,
        ST_GAP,
        ST_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          bitcnt_q, bitcnt_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [15:0]         shreg_q, shreg_d;
    logic [DIG_W-1:0]    digits_q, digits_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic                cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;

    logic                load;
    logic [15:0]         load_word;

    // Power-up register writes, indexed by word number.
    function automatic logic [15:0] init_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = 16'h0C01;
            3'd1:    w = {8'h09, DECODE_MASK};
            3'd2:    w = {8'h0B, 8'(NUM_DIGITS - 1)};
            3'd3:    w = {8'h0A, 4'h0, INTENSITY};
            default: w = 16'h0F00;
        endcase
        return w;
    endfunction

    // Digit register write for digit k: address k+1, DP in bit 7, raw BCD nibble.
    function automatic logic [15:0] frame_word(input logic [2:0]            k,
                                               input logic [DIG_W-1:0]      d,
                                               input logic [NUM_DIGITS-1:0] p);
        logic [3:0] bcd;
        logic       pt;
        bcd = 4'h0;
        pt  = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (k == 3'(i)) begin
                bcd = d[4*i +: 4];
                pt  = p[i];
            end
        end
        return {8'(k) + 8'd1, pt, 3'b000, bcd};
    endfunction

    // State and datapath registers; async reset parks the bus idle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= ST_INIT;
            idx_q    <= '0;
            bitcnt_q <= '0;
            half_q   <= '0;
            gap_q    <= '0;
            shreg_q  <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bitcnt_q <= bitcnt_d;
            half_q   <= half_d;
            gap_q    <= gap_d;
            shreg_q  <= shreg_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            cs_n_q   <= cs_n_d;
            sck_q    <= sck_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Next-state: word sequencing, bit timing and frame capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bitcnt_d  = bitcnt_q;
        half_d    = half_q;
        gap_d     = gap_q;
        shreg_d   = shreg_q;
        digits_d  = digits_q;
        dp_d      = dp_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        ready_d   = ready_q;
        done_d    = done_q;
        load      = 1'b0;
        load_word = 16'h0000;

        case (state_q)
            ST_INIT: begin
                idx_d     = 3'd0;
                load      = 1'b1;
                load_word = init_word(3'd0);
            end

            ST_SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // End of a bit: next bit (or zero after bit 0) onto mosi
                        sck_d   = 1'b0;
                        shreg_d = {shreg_q[14:0], 1'b0};
                        if (bitcnt_q == 4'd0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                            cs_n_d  = 1'b1;
                        end else begin
                            bitcnt_d = bitcnt_q - 4'd1;
                        end
                    end
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (done_q ? (idx_q == LAST_DIGIT) : (idx_q == LAST_INIT)) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        load      = 1'b1;
                        load_word = done_q ? frame_word(idx_d, digits_q, dp_q)
                                           : init_word(idx_d);
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_IDLE: begin
                if (bus.frame_valid && ready_q) begin
                    ready_d   = 1'b0;
                    digits_d  = bus.digits;
                    dp_d      = bus.dp;
                    idx_d     = 3'd0;
                    load      = 1'b1;
                    load_word = frame_word(3'd0, bus.digits, bus.dp);
                end
            end

            default: state_d = ST_INIT;
        endcase

        // Start a word: cs_n falls with bit 15 already presented
        if (load) begin
            state_d  = ST_SHIFT;
            shreg_d  = load_word;
            cs_n_d   = 1'b0;
            sck_d    = 1'b0;
            bitcnt_d = 4'd15;
            half_d   = '0;
        end
    end

    assign bus.cs_n        = cs_n_q;
    assign bus.sck         = sck_q;
    assign bus.mosi        = shreg_q[15];
    assign bus.frame_ready = ready_q;
    assign bus.init_done   = done_q;
endmodule

// File: tb/tb_spi_display_driver.sv
// Bench for spi_display_driver: three builds (6, 1 and 8 digits) checked
// every cycle against a waveform model derived from word lists and timing.
module tb_spi_display_driver;
    logic        clk;
    logic        res;
    logic        fv;
    logic [31:0] dsrc;
    logic [7:0]  psrc;

    int n_checks;
    int n_fail;
    int cyc;
    int ncnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_display_driver_if #(.NUM_DIGITS(6)) if0 ();
    spi_display_driver_if #(.NUM_DIGITS(1)) if1 ();
    spi_display_driver_if #(.NUM_DIGITS(8)) if2 ();

    assign if0.frame_valid = fv;
    assign if0.digits      = dsrc[23:0];
    assign if0.dp          = psrc[5:0];
    assign if1.frame_valid = fv;
    assign if1.digits      = dsrc[3:0];
    assign if1.dp          = psrc[0];
    assign if2.frame_valid = fv;
    assign if2.digits      = dsrc;
    assign if2.dp          = psrc;

    spi_display_driver #(.NUM_DIGITS(6), .SCK_HALF(2), .CS_GAP(4), .INTENSITY(4'h8))
        u0 (.clk(clk), .res(res), .bus(if0));
    spi_display_driver #(.NUM_DIGITS(1), .SCK_HALF(1), .CS_GAP(1), .INTENSITY(4'h8))
        u1 (.clk(clk), .res(res), .bus(if1));
    spi_display_driver #(.NUM_DIGITS(8), .SCK_HALF(3), .CS_GAP(2), .INTENSITY(4'hF))
        u2 (.clk(clk), .res(res), .bus(if2));

    logic [2:0] cs_v, sck_v, mosi_v, rdy_v, done_v;
    assign cs_v   = {if2.cs_n,        if1.cs_n,        if0.cs_n};
    assign sck_v  = {if2.sck,         if1.sck,         if0.sck};
    assign mosi_v = {if2.mosi,        if1.mosi,        if0.mosi};
    assign rdy_v  = {if2.frame_ready, if1.frame_ready, if0.frame_ready};
    assign done_v = {if2.init_done,   if1.init_done,   if0.init_done};

    function automatic int nd_of(int i);
        case (i)
            0:       return 6;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int sh_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int gap_of(int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int int_of(int i);
        return (i == 2) ? 15 : 8;
    endfunction

    // Model state: 0 = held/just reset, 1 = sending words, 2 = idle
    int          md   [3];
    int          tm   [3];
    int          wi   [3];
    int          wn   [3];
    logic [15:0] wq   [3][8];
    logic        rdy_m  [3];
    logic        done_m [3];

    // Bus decoder state
    logic        prev_cs   [3];
    logic        prev_sck  [3];
    logic [15:0] sh_dec    [3];
    int          nw        [3];
    logic [15:0] lit_tab   [3][11];
    int          nlit      [3];
    logic        prev_done0, prev_rdy0, t_done_chk, t_frame_chk;
    int          nfall0, c_fall0, c_fall5;

    function automatic logic [15:0] model_init_word(int i, int k);
        int nd = nd_of(i);
        case (k)
            0:       return 16'h0C01;
            1:       return {8'h09, 8'((1 << nd) - 1)};
            2:       return {8'h0B, 8'(nd - 1)};
            3:       return {8'h0A, 4'h0, 4'(int_of(i))};
            default: return 16'h0F00;
        endcase
    endfunction

    // Advance one clock edge using the inputs present at that edge.
    task automatic model_step(int i);
        int w = 32 * sh_of(i) + gap_of(i);
        if (res) begin
            md[i]     = 0;
            rdy_m[i]  = 1'b0;
            done_m[i] = 1'b0;
        end else if (md[i] == 0) begin
            for (int k = 0; k < 5; k++) wq[i][k] = model_init_word(i, k);
            wn[i] = 5;
            wi[i] = 0;
            tm[i] = 0;
            md[i] = 1;
        end else if (md[i] == 1) begin
            tm[i]++;
            if (tm[i] == w) begin
                tm[i] = 0;
                wi[i]++;
                if (wi[i] == wn[i]) begin
                    md[i]     = 2;
                    rdy_m[i]  = 1'b1;
                    done_m[i] = 1'b1;
                end
            end
        end else if (fv && rdy_m[i]) begin
            for (int k = 0; k < nd_of(i); k++)
                wq[i][k] = {8'(k + 1), psrc[k], 3'b000, dsrc[4*k +: 4]};
            wn[i]    = nd_of(i);
            wi[i]    = 0;
            tm[i]    = 0;
            md[i]    = 1;
            rdy_m[i] = 1'b0;
        end
    endtask

    // Expected {cs_n, sck, mosi} from word and offset within the word period.
    function automatic logic [2:0] model_spi(int i);
        int sh = sh_of(i);
        if (md[i] == 1 && tm[i] < 32 * sh) begin
            logic [15:0] w;
            int          b;
            w = wq[i][wi[i]];
            b = 15 - tm[i] / (2 * sh);
            return {1'b0, 1'((tm[i] % (2 * sh)) >= sh), w[b]};
        end
        return 3'b100;
    endfunction

    task automatic check(string name, int i, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s[%0d] cycle %0d: got %b expected %b", name, i, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, int i, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cycle %0d: got 0x%0h expected 0x%0h", name, i, cyc, act, exp);
        end
    endtask

    // Rebuild words from sck rising edges and pin early words / latencies.
    task automatic decode(int i);
        if (!res) begin
            if (!cs_v[i] && sck_v[i] && !prev_sck[i])
                sh_dec[i] = {sh_dec[i][14:0], mosi_v[i]};
            if (!prev_cs[i] && cs_v[i]) begin
                if (nw[i] < nlit[i])
                    check_int("word", i, int'(sh_dec[i]), int'(lit_tab[i][nw[i]]));
                nw[i]++;
            end
        end
        if (i == 0) begin
            if (prev_cs[0] && !cs_v[0] && !res) begin
                if (nfall0 == 0) c_fall0 = cyc;
                if (nfall0 == 5) c_fall5 = cyc;
                nfall0++;
            end
            if (!prev_done0 && done_v[0] && !t_done_chk) begin
                check_int("init_done latency", 0, cyc - c_fall0, 340);
                t_done_chk = 1'b1;
            end
            if (!prev_rdy0 && rdy_v[0] && nfall0 > 5 && !t_frame_chk) begin
                check_int("frame latency", 0, cyc - c_fall5, 408);
                t_frame_chk = 1'b1;
            end
            prev_done0 = done_v[0];
            prev_rdy0  = rdy_v[0];
        end
        prev_cs[i]  = cs_v[i];
        prev_sck[i] = sck_v[i];
    endtask

    // Compare process: full check after each rising edge, reset check on falling edges.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int i = 0; i < 3; i++) begin
            md[i] = 0; tm[i] = 0; wi[i] = 0; wn[i] = 0;
            rdy_m[i] = 1'b0; done_m[i] = 1'b0;
            prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; sh_dec[i] = '0; nw[i] = 0;
            for (int k = 0; k < 8; k++) wq[i][k] = '0;
            for (int k = 0; k < 11; k++) lit_tab[i][k] = '0;
        end
        lit_tab[0] = '{16'h0C01, 16'h093F, 16'h0B05, 16'h0A08, 16'h0F00,
                       16'h0101, 16'h0202, 16'h0383, 16'h0404, 16'h0585, 16'h0606};
        lit_tab[1][0] = 16'h0C01; lit_tab[1][1] = 16'h0901;
        lit_tab[1][2] = 16'h0B00; lit_tab[1][3] = 16'h0A08;
        lit_tab[2][0] = 16'h0C01; lit_tab[2][1] = 16'h09FF;
        lit_tab[2][2] = 16'h0B07; lit_tab[2][3] = 16'h0A0F;
        nlit[0] = 11; nlit[1] = 4; nlit[2] = 4;
        prev_done0 = 1'b0; prev_rdy0 = 1'b0;
        t_done_chk = 1'b0; t_frame_chk = 1'b0;
        nfall0 = 0; c_fall0 = 0; c_fall5 = 0;
        forever begin
            @(clk);
            #1;
            if (clk) begin
                cyc++;
                for (int i = 0; i < 3; i++) begin
                    logic [2:0] e;
                    model_step(i);
                    e = model_spi(i);
                    check("cs_n",        i, cs_v[i],   e[2]);
                    check("sck",         i, sck_v[i],  e[1]);
                    check("mosi",        i, mosi_v[i], e[0]);
                    check("frame_ready", i, rdy_v[i],  rdy_m[i]);
                    check("init_done",   i, done_v[i], done_m[i]);
                    decode(i);
                end
            end else if (res) begin
                for (int i = 0; i < 3; i++) begin
                    check("async cs_n",        i, cs_v[i],   1'b1);
                    check("async sck",         i, sck_v[i],  1'b0);
                    check("async mosi",        i, mosi_v[i], 1'b0);
                    check("async frame_ready", i, rdy_v[i],  1'b0);
                    check("async init_done",   i, done_v[i], 1'b0);
                end
            end
        end
    end

    task automatic next_neg();
        @(negedge clk);
        ncnt++;
    endtask

    task automatic to_neg(int target);
        while (ncnt < target) next_neg();
    endtask

    // Directed schedule; negedge 0 is the first reset release.
    initial begin
        res  = 1'b1;
        fv   = 1'b0;
        dsrc = '0;
        psrc = '0;
        ncnt = 0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        fv  = 1'b1;
        // frame_valid held through init with changing data
        while (ncnt < 340) begin
            dsrc = $urandom;
            psrc = 8'($urandom);
            next_neg();
        end
        dsrc = 32'h98654321;
        psrc = 8'b0001_0100;
        to_neg(342);
        dsrc = $urandom;
        psrc = 8'($urandom);
        fv   = 1'b0;
        // Second frame with non-BCD digits, then reset during bit 7 of word 3
        to_neg(752);
        dsrc = 32'hFEDCBA98;
        psrc = 8'hA5;
        fv   = 1'b1;
        to_neg(753);
        fv = 1'b0;
        to_neg(990);
        res = 1'b1;
        to_neg(993);
        res = 1'b0;
        fv  = 1'b1;
        while (ncnt < 1333) begin
            dsrc = $urandom;
            psrc = 8'($urandom);
            next_neg();
        end
        dsrc = 32'h13579BDF;
        psrc = 8'h3C;
        to_neg(1335);
        // Held valid: second frame follows back-to-back
        dsrc = 32'h2468ACE0;
        psrc = 8'hC3;
        to_neg(1744);
        fv = 1'b0;
        to_neg(2170);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_display_driver.md
# spi_display_driver

Parametrised MAX7219-style 7-segment display driver, the next-generation replacement for the fixed 6-digit SPI wrapper/master pair. It runs the display power-up sequence itself, accepts whole frames of BCD digits and decimal-point flags over a valid/ready handshake, and serialises one 16-bit SPI mode-0 word per digit. Digit count, SCK rate and inter-word CS gap are parameters, so the stopwatch counter chain and future clock/timer tops share one driver.

## Interface
- NUM_DIGITS, 6, digits driven; legal range 1..8.
- SCK_HALF, 2, clk cycles per SCK half-period; must be ≥1.
- CS_GAP, 4, clk cycles cs_n stays high between words; must be ≥1.
- INTENSITY, 4'h8, value written to the intensity register during init.

- clk  in  1  system clock; all logic on its rising edge.
- res  in  1  reset, asynchronous, active-high.
- frame_valid  in  1  a frame is offered on digits/dp.
- frame_ready  out  1  driver idle; accepts a frame when frame_valid=1.
- digits  in  4*NUM_DIGITS  BCD digit k at [4k+3:4k]; digit 0 is the rightmost display position.
- dp  in  NUM_DIGITS  decimal point for digit k.
- init_done  out  1  high once the init sequence has completed; stays high until reset.
- cs_n  out  1  SPI chip select, active low.
- sck  out  1  SPI clock, idle low.
- mosi  out  1  SPI data, MSB first.

## Operation
- Reset values: cs_n=1, sck=0, mosi=0, frame_ready=0, init_done=0. Asserting res mid-word forces these values immediately and abandons the word. After release, init restarts from word 0.
- FSM states and transitions:
  - INIT: loads init words in order.
  - SHIFT: clocks out one word.
  - GAP: holds cs_n high for CS_GAP cycles.
  - IDLE: waits for a frame.
  - Transitions: INIT→SHIFT→GAP→(next word: SHIFT | last init word: IDLE | last frame word: IDLE).
- Init words, in order:
  - 0x0C01: shutdown register, normal operation.
  - 0x09mm: decode mode, mm = (2^NUM_DIGITS)-1.
  - 0x0B(NUM_DIGITS-1): scan limit.
  - 0x0A0i: intensity, i = INTENSITY.
  - 0x0F00: display test off.
- init_done and frame_ready rise together, in the first IDLE cycle.
- Handshake: a frame transfers in any cycle with frame_valid=1 and frame_ready=1. In that cycle digits and dp are captured into an internal register, and frame_ready is 0 from the next cycle. Input changes after capture have no effect. frame_valid held during INIT is not accepted until IDLE.
- Frame words: for k=0..NUM_DIGITS-1 in ascending order, word = {8'(k+1), dp[k], 3'b000, digits[k]}. Digit values 10..15 pass through unmodified.
- SPI word, mode 0:
  - cs_n falls with bit 15 already on mosi.
  - Each bit is SCK_HALF cycles with sck low, then SCK_HALF cycles with sck high.
  - mosi changes only while sck is low, at the start of each bit's low phase.
  - After bit 0's high phase, cs_n rises, sck=0 and mosi=0 for the GAP.
- Word index counter is 3 bits wide and counts 0..4 during init and 0..NUM_DIGITS-1 during a frame. It never wraps past its last value.

## Timing
- Word period W = 32*SCK_HALF + CS_GAP cycles; cs_n low for exactly 32*SCK_HALF of them.
- First init word: cs_n falls on the first clk edge after res deasserts.
- init_done rises 5*W cycles after cs_n first falls (defaults: 340).
- Frame latency: cs_n falls the cycle after the handshake cycle.
- frame_ready returns NUM_DIGITS*W cycles after cs_n first falls (defaults: 408).
- Back-to-back frames: a frame_valid held high is accepted in the first IDLE cycle, so the idle gap between frames is 1 cycle plus CS_GAP.

## Test plan
- Defaults, release reset: capture words 0x0C01, 0x093F, 0x0B05, 0x0A08, 0x0F00 in order, and init_done=1 exactly 340 cycles after the first cs_n fall.
- After init, digits=24'h654321, dp=6'b010100: the frame transfers. Words 0x0101, 0x0202, 0x0383, 0x0404, 0x0585, 0x0606 follow, and frame_ready returns after 408 cycles.
- Waveform check, SCK_HALF=2 and CS_GAP=4: sck period 4 cycles, mosi stable across every sck rise, cs_n low for 64 cycles and high for 4 between words.
- frame_valid=1 from reset with changing digits: no capture before init_done. The frame sent holds the values present in the first IDLE cycle, and later changes are ignored.
- NUM_DIGITS=1 and NUM_DIGITS=8 builds: scan-limit words are 0x0B00 and 0x0B07, decode words are 0x0901 and 0x09FF, and frames carry 1 and 8 words respectively.
- Assert res during bit 7 of frame word 3: cs_n=1 and sck=0 without waiting for a clk edge. After release, the full init sequence is re-sent and frame_ready=0 until it completes.
